// File: rtl/irq_trap_ctrl_if.sv
// Bundle of core-side signals between the pipeline and the interrupt/trap controller.
// The controller uses the slave view; the core (or a bench) uses the master view.
interface irq_trap_ctrl_if #(
    parameter int NUM_IRQ = 4,
    parameter int XLEN    = 32
);
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_en;
    logic               gie;
    logic [XLEN-1:0]    mtvec;
    logic               wb_valid;
    logic [XLEN-1:0]    pc_wb;
    logic               is_mret;
    logic               trap_taken;
    logic               mret_taken;
    logic [XLEN-1:0]    redirect_pc;
    logic [XLEN-1:0]    mepc;
    logic [XLEN-1:0]    mcause;
    logic [NUM_IRQ-1:0] mip;
    logic               in_handler;

    modport master (
        output irq, irq_en, gie, mtvec, wb_valid, pc_wb, is_mret,
        input  trap_taken, mret_taken, redirect_pc, mepc, mcause, mip, in_handler
    );

    modport slave (
        input  irq, irq_en, gie, mtvec, wb_valid, pc_wb, is_mret,
        output trap_taken, mret_taken, redirect_pc, mepc, mcause, mip, in_handler
    );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap controller: latches level/edge sources, takes the lowest-index
// eligible interrupt at WB, redirects fetch (direct or vectored) and holds mepc/mcause until mret.
module irq_trap_ctrl #(
    parameter int                 NUM_IRQ   = 4,
    parameter int                 XLEN      = 32,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    irq_trap_ctrl_if.slave    bus
);

    localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] new_edge;
    logic [NUM_IRQ-1:0] mip_int;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [CW-1:0]      cause;
    logic               any_eligible;
    logic               take_trap;
    logic               take_mret;
    logic [XLEN-1:0]    mepc_q;
    logic [XLEN-1:0]    mcause_q;
    logic [XLEN-1:0]    trap_base;
    logic [XLEN-1:0]    vec_offset;
    logic [XLEN-1:0]    trap_target;
    logic               mtvec_unused;

    // Edge lines report their sticky latch; level lines pass straight through.
    assign new_edge = bus.irq & ~irq_prev & EDGE_MASK;
    assign mip_int  = (pending & EDGE_MASK) | (bus.irq & ~EDGE_MASK);
    assign eligible = mip_int & bus.irq_en;

    always_comb begin
        cause        = '0;
        any_eligible = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cause        = CW'(i);
                any_eligible = 1'b1;
            end
        end
    end

    assign trap_base    = {bus.mtvec[XLEN-1:2], 2'b00};
    assign vec_offset   = {{(XLEN-CW-2){1'b0}}, cause, 2'b00};
    assign trap_target  = bus.mtvec[0] ? (trap_base + vec_offset) : trap_base;
    assign mtvec_unused = bus.mtvec[1];

    // HANDLER masks everything, so a same-cycle mret always wins over a new interrupt.
    always_comb begin
        state_next = state;
        take_trap  = 1'b0;
        take_mret  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.gie && bus.wb_valid && any_eligible) begin
                        take_trap  = 1'b1;
                        state_next = HANDLER;
                    end
                end
                HANDLER: begin
                    if (bus.is_mret && bus.wb_valid) begin
                        take_mret  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign ack_mask     = take_trap ? (NUM_IRQ'(1) << cause) : '0;
    assign pending_next = ((pending & ~ack_mask) | new_edge) & EDGE_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            irq_prev <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            irq_prev <= bus.irq;
            if (take_trap) begin
                mepc_q   <= bus.pc_wb;
                mcause_q <= {1'b1, {(XLEN-1-CW){1'b0}}, cause};
            end
        end
    end

    assign bus.trap_taken  = take_trap;
    assign bus.mret_taken  = take_mret;
    assign bus.redirect_pc = take_trap ? trap_target : (take_mret ? mepc_q : '0);
    assign bus.mepc        = rst ? '0 : mepc_q;
    assign bus.mcause      = rst ? '0 : mcause_q;
    assign bus.mip         = rst ? '0 : mip_int;
    assign bus.in_handler  = !rst && (state == HANDLER);

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_irq_trap_ctrl;

    localparam logic [3:0] EDGE = 4'b1001;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    irq_trap_ctrl_if #(.NUM_IRQ(4), .XLEN(32)) bus ();

    irq_trap_ctrl #(.NUM_IRQ(4), .XLEN(32), .EDGE_MASK(EDGE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: handler flag, saved CSRs, sticky edge latches, previous irq sample.
    bit          m_hand;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [3:0]  m_pend;
    logic [3:0]  m_prev;

    bit          e_trap;
    bit          e_mret;
    logic [31:0] e_redir;
    logic [3:0]  e_mip;
    int          e_cause;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic [3:0] elig;
        e_trap  = 1'b0;
        e_mret  = 1'b0;
        e_redir = 32'h0;
        e_mip   = 4'h0;
        e_cause = -1;
        if (rst) return;
        for (int i = 0; i < 4; i++)
            e_mip[i] = EDGE[i] ? m_pend[i] : bus.irq[i];
        elig = e_mip & bus.irq_en;
        for (int i = 0; i < 4; i++)
            if (e_cause < 0 && elig[i]) e_cause = i;
        e_trap = !m_hand && bus.gie && bus.wb_valid && (e_cause >= 0);
        e_mret = m_hand && bus.is_mret && bus.wb_valid;
        if (e_trap)
            e_redir = (bus.mtvec & ~32'h3) + (bus.mtvec[0] ? 32'(4 * e_cause) : 32'h0);
        else if (e_mret)
            e_redir = m_mepc;
    endtask

    task automatic model_update();
        if (rst) begin
            m_hand   = 1'b0;
            m_mepc   = 32'h0;
            m_mcause = 32'h0;
            m_pend   = 4'h0;
            m_prev   = 4'h0;
            return;
        end
        if (e_trap) begin
            m_pend[e_cause] = 1'b0;
            m_mepc          = bus.pc_wb;
            m_mcause        = 32'h8000_0000 | 32'(e_cause);
            m_hand          = 1'b1;
        end else if (e_mret) begin
            m_hand = 1'b0;
        end
        m_pend = m_pend | (bus.irq & ~m_prev & EDGE);
        m_prev = bus.irq;
    endtask

    // Called with inputs already settled after a falling edge; returns at the next falling edge.
    task automatic step();
        #1;
        model_eval();
        check_output("trap_taken",  32'(bus.trap_taken),  32'(e_trap));
        check_output("mret_taken",  32'(bus.mret_taken),  32'(e_mret));
        check_output("redirect_pc", bus.redirect_pc,      e_redir);
        check_output("mip",         32'(bus.mip),         32'(e_mip));
        check_output("mepc",        bus.mepc,             rst ? 32'h0 : m_mepc);
        check_output("mcause",      bus.mcause,           rst ? 32'h0 : m_mcause);
        check_output("in_handler",  32'(bus.in_handler),  32'(!rst && m_hand));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [3:0] irq_v, input logic [3:0] en_v, input logic gie_v,
                                  input logic wbv_v, input logic mret_v, input logic [31:0] pc_v);
        bus.irq      = irq_v;
        bus.irq_en   = en_v;
        bus.gie      = gie_v;
        bus.wb_valid = wbv_v;
        bus.is_mret  = mret_v;
        bus.pc_wb    = pc_v;
        #1;
    endtask

    initial begin
        m_hand = 1'b0; m_mepc = '0; m_mcause = '0; m_pend = '0; m_prev = '0;
        rst       = 1'b1;
        bus.mtvec = 32'h201;

        // Reset with everything asserted
        apply_stimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 32'h100);
        check_output("rst_trap", 32'(bus.trap_taken), 32'h0);
        check_output("rst_mip",  32'(bus.mip),        32'h0);
        step();
        check_output("rst_mepc",   bus.mepc,   32'h0);
        check_output("rst_mcause", bus.mcause, 32'h0);
        step();
        rst = 1'b0;
        apply_stimulus(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h100);
        step();
        step();

        // Level irq[2], vectored then direct
        apply_stimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0, 32'h100);
        check_output("t2_trap",  32'(bus.trap_taken), 32'h1);
        check_output("t2_redir", bus.redirect_pc,     32'h208);
        step();
        apply_stimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b1, 32'h180);
        check_output("t2_mepc",   bus.mepc,            32'h100);
        check_output("t2_mcause", bus.mcause,          32'h8000_0002);
        check_output("t2_inh",    32'(bus.in_handler), 32'h1);
        check_output("t2_mret",   32'(bus.mret_taken), 32'h1);
        check_output("t2_mredir", bus.redirect_pc,     32'h100);
        step();
        bus.mtvec = 32'h200;
        apply_stimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0, 32'h100);
        check_output("t2_direct", bus.redirect_pc, 32'h200);
        step();
        apply_stimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b1, 32'h100);
        step();

        // Simultaneous irq[1] (level) and irq[3] (edge): priority, then masking by irq_en
        bus.mtvec = 32'h201;
        apply_stimulus(4'b1010, 4'hF, 1'b1, 1'b1, 1'b0, 32'h140);
        check_output("t3_redir1", bus.redirect_pc, 32'h204);
        step();
        check_output("t3_cause1", bus.mcause, 32'h8000_0001);
        apply_stimulus(4'b1010, 4'b1000, 1'b1, 1'b1, 1'b1, 32'h140);
        step();
        apply_stimulus(4'b1010, 4'b1000, 1'b1, 1'b1, 1'b0, 32'h144);
        check_output("t3_trap3",  32'(bus.trap_taken), 32'h1);
        check_output("t3_redir3", bus.redirect_pc,     32'h20C);
        step();
        check_output("t3_cause3", bus.mcause, 32'h8000_0003);
        apply_stimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b1, 32'h144);
        step();

        // Edge pulse on irq[3] held while gie=0
        apply_stimulus(4'b1000, 4'hF, 1'b0, 1'b1, 1'b0, 32'h300);
        step();
        apply_stimulus(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 32'h300);
        check_output("t4_mip_held", 32'(bus.mip),        32'h8);
        check_output("t4_no_trap",  32'(bus.trap_taken), 32'h0);
        step();
        apply_stimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0, 32'h300);
        check_output("t4_trap", 32'(bus.trap_taken), 32'h1);
        step();
        check_output("t4_mip_clr", 32'(bus.mip),   32'h0);
        check_output("t4_cause",   bus.mcause,     32'h8000_0003);

        // Edge accumulates in HANDLER; mret then trap; mret beats same-cycle interrupt
        apply_stimulus(4'b0001, 4'hF, 1'b1, 1'b1, 1'b0, 32'h310);
        step();
        apply_stimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0, 32'h310);
        check_output("t5_masked",  32'(bus.trap_taken), 32'h0);
        check_output("t5_mip0",    32'(bus.mip),        32'h1);
        step();
        apply_stimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b1, 32'h310);
        check_output("t5_mret",    32'(bus.mret_taken), 32'h1);
        check_output("t5_mredir",  bus.redirect_pc,     32'h300);
        step();
        apply_stimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0, 32'h400);
        check_output("t5_trap0",   32'(bus.trap_taken), 32'h1);
        step();
        check_output("t5_cause0",  bus.mcause, 32'h8000_0000);
        apply_stimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b1, 32'h404);
        check_output("t5_mret_win", 32'(bus.mret_taken), 32'h1);
        check_output("t5_no_trap",  32'(bus.trap_taken), 32'h0);
        step();
        apply_stimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0, 32'h408);
        check_output("t5_late_trap", 32'(bus.trap_taken), 32'h1);
        step();
        apply_stimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b1, 32'h408);
        step();

        // Trap deferred by wb_valid=0; reset while in HANDLER
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(4'b0100, 4'hF, 1'b1, 1'b0, 1'b0, 32'h500);
            check_output("t6_defer", 32'(bus.trap_taken), 32'h0);
            step();
        end
        apply_stimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0, 32'h500);
        check_output("t6_trap", 32'(bus.trap_taken), 32'h1);
        step();
        rst = 1'b1;
        apply_stimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b1, 32'h500);
        check_output("t6_rst_mret", 32'(bus.mret_taken), 32'h0);
        step();
        rst = 1'b0;
        apply_stimulus(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 32'h500);
        check_output("t6_idle", 32'(bus.in_handler), 32'h0);
        check_output("t6_mepc", bus.mepc,            32'h0);
        step();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 79) == 0);
            bus.irq      = bus.irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            bus.irq_en   = 4'($urandom) | 4'($urandom);
            bus.gie      = ($urandom_range(0, 7) != 0);
            bus.wb_valid = ($urandom_range(0, 3) != 0);
            bus.is_mret  = ($urandom_range(0, 2) == 0);
            bus.pc_wb    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 15) == 0)
                bus.mtvec = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
